// File: rtl/ntt_engine_seq.sv
// Sequential Kyber NTT / inverse NTT engine: one butterfly per cycle on a 2R2W register-file
// coefficient memory, on-chip zeta ROM, Barrett reduction, and an N^-1 scaling pass for inverse.
module ntt_engine_seq #(
   parameter int N         = 256,
   parameter int Q         = 3329,
   parameter int COEFF_W   = 12,
   parameter int ZETA_ROOT = 17,
   parameter int N_INV     = 3303
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 wr_en,
   input  logic [$clog2(N)-1:0] wr_addr,
   input  logic [COEFF_W-1:0]   wr_data,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [COEFF_W-1:0]   rd_data,
   output logic                 busy,
   output logic                 done
);
   localparam int AW        = $clog2(N);
   localparam int AW1       = AW + 1;
   localparam int KW        = AW - 1;
   localparam int SW        = COEFF_W + 1;
   localparam int RW        = COEFF_W + 2;
   localparam int PW        = 2 * COEFF_W;
   localparam int MW        = PW + COEFF_W + 1;
   localparam int NUM_BF    = (N / 2) * (AW - 1);
   localparam int CW        = $clog2((NUM_BF > N) ? NUM_BF : N);
   localparam int BARRETT_M = (2 ** PW) / Q;

   localparam logic [SW-1:0]      Q_S     = SW'(Q);
   localparam logic [RW-1:0]      Q_R     = RW'(Q);
   localparam logic [PW-1:0]      Q_P     = PW'(Q);
   localparam logic [MW-1:0]      M_M     = MW'(BARRETT_M);
   localparam logic [COEFF_W-1:0] N_INV_C = COEFF_W'(N_INV);
   localparam logic [AW1-1:0]     N_A     = AW1'(N);
   localparam logic [CW-1:0]      LAST_BF = CW'(NUM_BF - 1);
   localparam logic [CW-1:0]      LAST_SC = CW'(N - 1);
   localparam logic [AW-1:0]      LEN_FWD = AW'(N / 2);
   localparam logic [AW-1:0]      LEN_INV = AW'(2);
   localparam logic [KW-1:0]      K_FWD   = KW'(1);
   localparam logic [KW-1:0]      K_INV   = KW'(N / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCALE, S_DONE} state_t;

   function automatic logic [COEFF_W-1:0] add_mod(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
      logic [SW-1:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q_S) s = s - Q_S;
      return s[COEFF_W-1:0];
   endfunction

   // Operands are canonical, so the MSB of the widened difference is the borrow.
   function automatic logic [COEFF_W-1:0] sub_mod(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
      logic [SW-1:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[COEFF_W]) d = d + Q_S;
      return d[COEFF_W-1:0];
   endfunction

   // Barrett with a floored constant underestimates the quotient by at most 2.
   function automatic logic [COEFF_W-1:0] mul_mod(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
      logic [PW-1:0] x;
      logic [MW-1:0] xm;
      logic [PW-1:0] q_est;
      logic [RW-1:0] r;
      x     = {{COEFF_W{1'b0}}, a} * {{COEFF_W{1'b0}}, b};
      xm    = MW'(x) * M_M;
      q_est = PW'(xm >> PW);
      r     = RW'(x - q_est * Q_P);
      if (r >= Q_R) r = r - Q_R;
      if (r >= Q_R) r = r - Q_R;
      return r[COEFF_W-1:0];
   endfunction

   function automatic logic [COEFF_W-1:0] reduce_in(input logic [COEFF_W-1:0] w);
      logic [SW-1:0] v;
      v = {1'b0, w};
      if (v >= Q_S) v = v - Q_S;
      return v[COEFF_W-1:0];
   endfunction

   function automatic logic [COEFF_W-1:0] zeta_calc(input int k);
      int     br;
      longint p;
      br = 0;
      for (int i = 0; i < KW; i++)
         if (((k >> i) & 1) != 0) br = br | (1 << (KW - 1 - i));
      p = 1;
      for (int i = 0; i < br; i++) p = (p * ZETA_ROOT) % Q;
      return COEFF_W'(p);
   endfunction

   logic [COEFF_W-1:0] zeta_rom [N/2];
   for (genvar gi = 0; gi < N / 2; gi++) begin : g_zeta
      localparam logic [COEFF_W-1:0] ZV = zeta_calc(gi);
      assign zeta_rom[gi] = ZV;
   end

   logic [COEFF_W-1:0] mem [N];
   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [AW-1:0]      base_reg, off_reg, len_reg;
   logic [KW-1:0]      k_reg;
   logic               mode_reg;

   logic [AW-1:0]      a_addr, b_addr, s_addr;
   logic [AW1-1:0]     blk_end;
   logic [COEFF_W-1:0] fa, fb, diff, mul_a, mul_b, prod, res_a, res_b;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (cnt_reg == LAST_BF) state_next = mode_reg ? S_SCALE : S_DONE;
         S_SCALE: if (cnt_reg == LAST_SC) state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == S_RUN) || (state_reg == S_SCALE);
      done = (state_reg == S_DONE);
   end

   always_comb begin
      a_addr  = base_reg + off_reg;
      b_addr  = a_addr + len_reg;
      s_addr  = cnt_reg[AW-1:0];
      blk_end = {1'b0, base_reg} + {len_reg, 1'b0};
      fa      = mem[a_addr];
      fb      = mem[b_addr];
      diff    = sub_mod(fb, fa);
      if (state_reg == S_SCALE) begin
         mul_a = mem[s_addr];
         mul_b = N_INV_C;
      end else begin
         mul_a = mode_reg ? diff : fb;
         mul_b = zeta_rom[k_reg];
      end
      prod = mul_mod(mul_a, mul_b);
      if (mode_reg) begin
         res_a = add_mod(fa, fb);
         res_b = prod;
      end else begin
         res_a = add_mod(fa, prod);
         res_b = sub_mod(fa, prod);
      end
   end

   // Address walk: offset within block, then next block, then next layer.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         base_reg <= '0;
         off_reg  <= '0;
         len_reg  <= '0;
         k_reg    <= '0;
         mode_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: if (start) begin
               cnt_reg  <= '0;
               base_reg <= '0;
               off_reg  <= '0;
               mode_reg <= mode;
               len_reg  <= mode ? LEN_INV : LEN_FWD;
               k_reg    <= mode ? K_INV : K_FWD;
            end
            S_RUN: begin
               cnt_reg <= (cnt_reg == LAST_BF) ? '0 : cnt_reg + 1'b1;
               if (off_reg == len_reg - 1'b1) begin
                  off_reg <= '0;
                  k_reg   <= mode_reg ? k_reg - 1'b1 : k_reg + 1'b1;
                  if (blk_end == N_A) begin
                     base_reg <= '0;
                     len_reg  <= mode_reg ? {len_reg[AW-2:0], 1'b0} : {1'b0, len_reg[AW-1:1]};
                  end else begin
                     base_reg <= blk_end[AW-1:0];
                  end
               end else begin
                  off_reg <= off_reg + 1'b1;
               end
            end
            S_SCALE: cnt_reg <= cnt_reg + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_reg == S_IDLE) begin
         if (wr_en) mem[wr_addr] <= reduce_in(wr_data);
      end else if (state_reg == S_RUN) begin
         mem[a_addr] <= res_a;
         mem[b_addr] <= res_b;
      end else if (state_reg == S_SCALE) begin
         mem[s_addr] <= prod;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule
